// File: rtl/gfsk_pkg.sv
// gfsk_pkg: shared state type, frequency codes and preamble for the GFSK transmit sequencer
// Exports: gfsk_state_t, OFF/ZERO/MID/ONE codes, PREAMBLE byte, bit_code() helper
package gfsk_pkg;
    typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_ADDR, S_LEN, S_PAYLOAD, S_TAIL} gfsk_state_t;
    localparam logic [2:0] OFF  = 3'd0;
    localparam logic [2:0] ZERO = 3'd2;
    localparam logic [2:0] MID  = 3'd4;
    localparam logic [2:0] ONE  = 3'd6;
    localparam logic [7:0] PREAMBLE = 8'hAA;
    function automatic logic [2:0] bit_code(input logic b);
        return b ? ONE : ZERO;
    endfunction
endpackage

// File: rtl/gfsk_tx_sequencer_if.sv
// gfsk_tx_sequencer_if: frame request, payload handshake and modulator output bundle
// master: start/access_addr/length/data_valid/data out; data_ready/busy/done/underrun/gfsk_out in
// slave: the sequencer side of the same signals
interface gfsk_tx_sequencer_if;
    logic        start;
    logic [31:0] access_addr;
    logic [7:0]  length;
    logic        data_valid;
    logic [7:0]  data;
    logic        data_ready;
    logic        busy;
    logic        done;
    logic        underrun;
    logic [2:0]  gfsk_out;
    modport master (
        output start, access_addr, length, data_valid, data,
        input  data_ready, busy, done, underrun, gfsk_out
    );
    modport slave (
        input  start, access_addr, length, data_valid, data,
        output data_ready, busy, done, underrun, gfsk_out
    );
endinterface

// File: rtl/gfsk_symbol_shaper.sv
// gfsk_symbol_shaper: per-bit symbol timing and bit-to-frequency-code mapping
// clock/reset: sync active-high; load: first bit of a frame; run: frame in progress
// stop: force carrier off; tail: upcoming symbol is the tail; bit_in: bit taking effect next cycle
// sym_last/sym_penult: current cycle is last/second-to-last of its bit; code: registered frequency code
module gfsk_symbol_shaper
    import gfsk_pkg::*;
#(
    parameter int SYMBOL_CYCLES = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic       run,
    input  logic       stop,
    input  logic       tail,
    input  logic       bit_in,
    output logic       sym_last,
    output logic       sym_penult,
    output logic [2:0] code
);
    localparam int SW = $clog2(SYMBOL_CYCLES);
    logic [SW-1:0] sym;
    logic          prev;
    assign sym_last   = sym == SW'(SYMBOL_CYCLES - 1);
    assign sym_penult = sym == SW'(SYMBOL_CYCLES - 2);
    // The frame's first bit goes straight to its steady code; later bits show MID on their
    // first cycle only when they differ from the bit before.
    always_ff @(posedge clock) begin
        if (reset || stop) begin
            sym  <= '0;
            prev <= 1'b0;
            code <= OFF;
        end else if (load) begin
            sym  <= '0;
            prev <= bit_in;
            code <= bit_code(bit_in);
        end else if (run && sym_last) begin
            sym  <= '0;
            prev <= bit_in;
            code <= (tail || bit_in != prev) ? MID : bit_code(bit_in);
        end else if (run) begin
            sym  <= sym + SW'(1);
            code <= tail ? MID : bit_code(prev);
        end
    end
endmodule

// File: rtl/gfsk_tx_sequencer.sv
// gfsk_tx_sequencer: serialises preamble, access address, length and payload into GFSK codes
// clock/reset: sync active-high; tx: slave side of gfsk_tx_sequencer_if
// Frame: PREAMBLE(8) ADDR(32) LEN(8) PAYLOAD(8*length) TAIL(1 symbol), all LSB first
module gfsk_tx_sequencer
    import gfsk_pkg::*;
#(
    parameter int SYMBOL_CYCLES = 10
) (
    input  logic clock,
    input  logic reset,
    gfsk_tx_sequencer_if.slave tx
);
    gfsk_state_t state;
    logic [31:0] sr;
    logic [31:0] addr_q;
    logic [4:0]  bit_idx;
    logic [7:0]  byte_cnt;
    logic        ready_q;
    logic        done_q;
    logic        under_q;
    logic        sym_last;
    logic        sym_penult;
    logic [2:0]  code;
    logic        busy;
    logic        byte_field;
    logic        field_last;
    logic        bnd;
    logic        fend;
    logic        accept;
    logic        take;
    logic        under;
    logic        fin;
    logic        to_tail;
    logic        bit_nxt;
    // sr holds the bits still to come after the one on air, so sr[0] is always the next bit.
    // byte_cnt doubles as the LEN field value since it only starts counting after LEN.
    always_comb begin
        busy       = state != S_IDLE;
        byte_field = state == S_LEN || state == S_PAYLOAD;
        field_last = state == S_TAIL || bit_idx == ((state == S_ADDR) ? 5'd31 : 5'd7);
        bnd        = busy && sym_last;
        fend       = bnd && field_last;
        accept     = !busy && tx.start;
        take       = ready_q && tx.data_valid;
        under      = ready_q && !tx.data_valid;
        fin        = fend && state == S_TAIL;
        to_tail    = fend && byte_field && byte_cnt == 8'd0;
        bit_nxt    = accept ? PREAMBLE[0] :
                     !fend ? sr[0] :
                     state == S_PREAMBLE ? addr_q[0] :
                     state == S_ADDR ? byte_cnt[0] :
                     take && tx.data[0];
    end
    gfsk_symbol_shaper #(.SYMBOL_CYCLES(SYMBOL_CYCLES)) u_shaper (
        .clock      (clock),
        .reset      (reset),
        .load       (accept),
        .run        (busy),
        .stop       (under || fin),
        .tail       (state == S_TAIL || to_tail),
        .bit_in     (bit_nxt),
        .sym_last   (sym_last),
        .sym_penult (sym_penult),
        .code       (code)
    );
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            sr       <= '0;
            addr_q   <= '0;
            bit_idx  <= '0;
            byte_cnt <= '0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            under_q  <= 1'b0;
        end else begin
            done_q  <= fin;
            under_q <= under;
            // Raised one cycle early so it is high exactly during the last cycle of bit 7.
            ready_q <= byte_field && bit_idx == 5'd7 && sym_penult && byte_cnt != 8'd0;
            if (accept) begin
                state    <= S_PREAMBLE;
                sr       <= {25'h0, PREAMBLE[7:1]};
                addr_q   <= tx.access_addr;
                byte_cnt <= tx.length;
                bit_idx  <= '0;
            end else if (under || fin) begin
                state   <= S_IDLE;
                sr      <= '0;
                bit_idx <= '0;
            end else if (bnd && !field_last) begin
                sr      <= sr >> 1;
                bit_idx <= bit_idx + 5'd1;
            end else if (fend) begin
                bit_idx <= '0;
                case (state)
                    S_PREAMBLE: begin
                        state <= S_ADDR;
                        sr    <= {1'b0, addr_q[31:1]};
                    end
                    S_ADDR: begin
                        state <= S_LEN;
                        sr    <= {25'h0, byte_cnt[7:1]};
                    end
                    default: begin
                        if (take) begin
                            state    <= S_PAYLOAD;
                            sr       <= {25'h0, tx.data[7:1]};
                            byte_cnt <= byte_cnt - 8'd1;
                        end else begin
                            state <= S_TAIL;
                            sr    <= '0;
                        end
                    end
                endcase
            end
        end
    end
    assign tx.busy       = busy;
    assign tx.data_ready = ready_q;
    assign tx.done       = done_q;
    assign tx.underrun   = under_q;
    assign tx.gfsk_out   = code;
endmodule

// File: tb/tb_gfsk_tx_sequencer.sv
// tb_gfsk_tx_sequencer: directed self-checking bench for gfsk_tx_sequencer at SYMBOL_CYCLES 10 and 2
module tb_gfsk_tx_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    gfsk_tx_sequencer_if i10 ();
    gfsk_tx_sequencer_if i2 ();

    gfsk_tx_sequencer #(.SYMBOL_CYCLES(10)) d10 (.clock(clock), .reset(reset), .tx(i10.slave));
    gfsk_tx_sequencer #(.SYMBOL_CYCLES(2))  d2  (.clock(clock), .reset(reset), .tx(i2.slave));

    assign i2.access_addr = i10.access_addr;
    assign i2.length      = i10.length;
    assign i2.data        = i10.data;
    assign i2.data_valid  = i10.data_valid;

    int compared = 0;
    int mismatched = 0;
    logic [2:0] trace [0:1023];
    logic       fbits [0:2047];
    int         nb;
    logic [7:0] payload [0:7];
    int busy_n, hs_n, dr_n, done_at, un_at, end_c;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected frame bit stream, LSB first per field.
    task automatic build(input logic [31:0] a, input logic [7:0] len, input int nbytes);
        logic [7:0] pre;
        pre = 8'hAA;
        nb = 0;
        for (int i = 0; i < 8; i++) begin fbits[nb] = pre[i]; nb++; end
        for (int i = 0; i < 32; i++) begin fbits[nb] = a[i]; nb++; end
        for (int i = 0; i < 8; i++) begin fbits[nb] = len[i]; nb++; end
        for (int j = 0; j < nbytes; j++)
            for (int i = 0; i < 8; i++) begin fbits[nb] = payload[j][i]; nb++; end
    endtask

    function automatic logic [2:0] exp_code(input int c, input int sc);
        int b, k;
        b = (c - 1) / sc;
        k = (c - 1) % sc;
        if (b < nb) begin
            if (k == 0 && b > 0 && fbits[b] != fbits[b-1]) return 3'd4;
            return fbits[b] ? 3'd6 : 3'd2;
        end
        return (b == nb) ? 3'd4 : 3'd0;
    endfunction

    task automatic wave(input string tag, input int sc, input int upto);
        for (int c = 1; c <= upto; c++)
            check($sformatf("%s c%0d", tag, c), {29'h0, trace[c]}, {29'h0, exp_code(c, sc)});
    endtask

    task automatic start_frame(input bit s2, input logic [31:0] a, input logic [7:0] len);
        i10.access_addr = a;
        i10.length      = len;
        i10.data        = payload[0];
        i10.data_valid  = 1'b1;
        if (s2) i2.start = 1'b1; else i10.start = 1'b1;
        tick;
        i2.start  = 1'b0;
        i10.start = 1'b0;
    endtask

    // Records one frame cycle by cycle, feeding payload bytes on each handshake.
    task automatic capture(input bit s2, input int limit, input int hs_lim, input int spam_to);
        logic bz, dn, un, dr, hs;
        int pidx;
        busy_n = 0; hs_n = 0; dr_n = 0; done_at = 0; un_at = 0; end_c = 0; pidx = 0;
        for (int c = 1; c <= limit; c++) begin
            trace[c] = s2 ? i2.gfsk_out : i10.gfsk_out;
            bz = s2 ? i2.busy : i10.busy;
            dn = s2 ? i2.done : i10.done;
            un = s2 ? i2.underrun : i10.underrun;
            dr = s2 ? i2.data_ready : i10.data_ready;
            if (bz) busy_n++;
            if (dn) done_at = c;
            if (un) un_at = c;
            if (dr) dr_n++;
            hs = dr && i10.data_valid;
            if (!bz) begin
                end_c = c;
                break;
            end
            if (spam_to > 0) begin
                i10.start       = c < spam_to;
                i10.access_addr = 32'hDEADBEEF;
                i10.length      = 8'd5;
            end
            tick;
            if (hs) begin
                hs_n++;
                pidx++;
                i10.data = payload[pidx];
                if (hs_n >= hs_lim) i10.data_valid = 1'b0;
            end
        end
        i10.start = 1'b0;
    endtask

    initial begin
        i10.start = 1'b0;
        i2.start = 1'b0;
        i10.access_addr = '0;
        i10.length = '0;
        i10.data = '0;
        i10.data_valid = 1'b0;
        for (int i = 0; i < 8; i++) payload[i] = 8'h00;

        tick;
        tick;
        check("reset_state", {25'h0, i10.busy, i10.done, i10.underrun, i10.data_ready, i10.gfsk_out}, 0);
        check("reset_state_sc2", {25'h0, i2.busy, i2.done, i2.underrun, i2.data_ready, i2.gfsk_out}, 0);
        reset = 1'b0;
        tick;
        check("idle_after_reset", {25'h0, i10.busy, i10.done, i10.underrun, i10.data_ready, i10.gfsk_out}, 0);

        // Two always-valid bytes FF, 00.
        payload[0] = 8'hFF;
        payload[1] = 8'h00;
        build(32'h8E89BED6, 8'd2, 2);
        start_frame(1'b0, 32'h8E89BED6, 8'd2);
        capture(1'b0, 1000, 255, 0);
        check("len2_busy", busy_n, 650);
        check("len2_end", end_c, 651);
        check("len2_done_at", done_at, 651);
        check("len2_underrun", un_at, 0);
        check("len2_handshakes", hs_n, 2);
        check("len2_ready_cycles", dr_n, 2);
        check("len2_pay_first", {29'h0, trace[481]}, 4);
        check("len2_pay_steady", {29'h0, trace[482]}, 6);
        check("len2_pay_b0_last", {29'h0, trace[560]}, 6);
        check("len2_pay_b1_mid", {29'h0, trace[561]}, 4);
        check("len2_pay_b1_steady", {29'h0, trace[562]}, 2);
        check("len2_pay_b1_last", {29'h0, trace[640]}, 2);
        check("len2_tail_first", {29'h0, trace[641]}, 4);
        check("len2_tail_last", {29'h0, trace[650]}, 4);
        check("len2_off_at_done", {29'h0, trace[651]}, 0);
        wave("len2_wave", 10, 651);

        // Start in the done cycle, empty payload.
        build(32'h8E89BED6, 8'd0, 0);
        start_frame(1'b0, 32'h8E89BED6, 8'd0);
        check("start_in_done_busy", {31'h0, i10.busy}, 1);
        capture(1'b0, 1000, 255, 0);
        check("len0_busy", busy_n, 490);
        check("len0_done_at", done_at, 491);
        check("len0_end", end_c, 491);
        check("len0_ready_never", dr_n, 0);
        check("len0_underrun", un_at, 0);
        check("len0_c1", {29'h0, trace[1]}, 2);
        check("len0_c10", {29'h0, trace[10]}, 2);
        check("len0_c11", {29'h0, trace[11]}, 4);
        check("len0_c12", {29'h0, trace[12]}, 6);
        check("len0_c20", {29'h0, trace[20]}, 6);
        check("len0_c21", {29'h0, trace[21]}, 4);
        wave("len0_wave", 10, 491);

        // Underrun: byte 2 never offered.
        tick;
        tick;
        payload[0] = 8'h3C;
        build(32'hA5A5F00F, 8'd3, 1);
        start_frame(1'b0, 32'hA5A5F00F, 8'd3);
        capture(1'b0, 1000, 1, 0);
        check("und_handshakes", hs_n, 1);
        check("und_ready_cycles", dr_n, 2);
        check("und_busy", busy_n, 560);
        check("und_end", end_c, 561);
        check("und_pulse_at", un_at, 561);
        check("und_no_done", done_at, 0);
        check("und_off", {29'h0, trace[561]}, 0);
        wave("und_wave", 10, 560);
        tick;
        check("und_one_cycle", {30'h0, i10.underrun, i10.done}, 0);

        // Start hammered during a frame with different fields.
        payload[0] = 8'hC3;
        build(32'h12345678, 8'd1, 1);
        start_frame(1'b0, 32'h12345678, 8'd1);
        capture(1'b0, 1000, 255, 400);
        check("spam_busy", busy_n, 570);
        check("spam_done_at", done_at, 571);
        check("spam_handshakes", hs_n, 1);
        wave("spam_wave", 10, 571);
        tick;
        check("spam_single_frame", {31'h0, i10.busy}, 0);

        // Reset during preamble bit 3, then a clean frame.
        build(32'h8E89BED6, 8'd0, 0);
        start_frame(1'b0, 32'h8E89BED6, 8'd0);
        for (int i = 0; i < 31; i++) tick;
        check("pre_bit3", {29'h0, i10.gfsk_out}, 6);
        reset = 1'b1;
        tick;
        check("reset_midframe", {25'h0, i10.busy, i10.done, i10.underrun, i10.data_ready, i10.gfsk_out}, 0);
        reset = 1'b0;
        tick;
        check("after_reset_quiet", {25'h0, i10.busy, i10.done, i10.underrun, i10.data_ready, i10.gfsk_out}, 0);
        start_frame(1'b0, 32'h8E89BED6, 8'd0);
        capture(1'b0, 1000, 255, 0);
        check("post_reset_busy", busy_n, 490);
        check("post_reset_done_at", done_at, 491);
        wave("post_reset_wave", 10, 491);

        // Two cycles per bit, one byte 5A.
        payload[0] = 8'h5A;
        build(32'h8E89BED6, 8'd1, 1);
        start_frame(1'b1, 32'h8E89BED6, 8'd1);
        capture(1'b1, 300, 255, 0);
        check("sc2_busy", busy_n, 114);
        check("sc2_end", end_c, 115);
        check("sc2_done_at", done_at, 115);
        check("sc2_handshakes", hs_n, 1);
        check("sc2_pre_mid", {29'h0, trace[3]}, 4);
        check("sc2_pre_steady", {29'h0, trace[4]}, 6);
        check("sc2_pay_b0", {29'h0, trace[97]}, 2);
        check("sc2_pay_b1_mid", {29'h0, trace[99]}, 4);
        check("sc2_pay_b1_steady", {29'h0, trace[100]}, 6);
        wave("sc2_wave", 2, 115);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/gfsk_tx_sequencer.md
GFSK_TX_SEQUENCER -- requirements
Module: gfsk_tx_sequencer

Interface
REQ-001 SHALL have parameter SYMBOL_CYCLES, default 10, clock cycles per transmitted bit (legal >= 2; 10 MHz clock gives 1 Mbit/s).
REQ-002 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port start  in  1  one-cycle frame request; sampled only in IDLE.
REQ-005 SHALL have port access_addr  in  32  frame access address; captured on accepted start.
REQ-006 SHALL have port length  in  8  payload byte count (0..255); captured on accepted start.
REQ-007 SHALL have port data_valid  in  1  payload byte available.
REQ-008 SHALL have port data  in  8  payload byte.
REQ-009 SHALL have port data_ready  out  1  payload byte consumed when data_valid & data_ready.
REQ-010 SHALL have port busy  out  1  high in every state except IDLE.
REQ-011 SHALL have port done  out  1  one-cycle pulse on normal frame completion.
REQ-012 SHALL have port underrun  out  1  one-cycle pulse on payload abort.
REQ-013 SHALL have port gfsk_out  out  3  frequency code to modulator; 0 = carrier off.

Function
REQ-014 SHALL implement states IDLE, PREAMBLE (8 bits), ADDR (32 bits), LEN (8 bits), PAYLOAD (8*length bits), TAIL (1 symbol), in that order.
REQ-015 SHALL accept start only in IDLE; start while busy is ignored, captured fields unchanged.
REQ-016 Start accepted at edge N SHALL produce the first preamble code at cycle N+1.
REQ-017 SHALL send every field LSB first; preamble value fixed 8'hAA (bits 0,1,0,1...).
REQ-018 Each bit SHALL last exactly SYMBOL_CYCLES cycles, counted by a symbol counter that wraps at SYMBOL_CYCLES-1.
REQ-019 Bit-cycle code: '1' -> 6, '0' -> 2; first cycle of a bit differing from the previous bit -> 4 (midpoint); frame's first bit has no midpoint.
REQ-020 TAIL SHALL output code 4 for SYMBOL_CYCLES cycles, then gfsk_out = 0, busy = 0, done = 1 in that same cycle.
REQ-021 Total busy duration SHALL be (49 + 8*length)*SYMBOL_CYCLES cycles.
REQ-022 length = 0 SHALL go LEN -> TAIL, asserting data_ready never.
REQ-023 data_ready SHALL be high only in the last cycle of the last bit of LEN or of a payload byte when at least one payload byte remains.
REQ-024 If data_valid is low when data_ready is high, SHALL next cycle: gfsk_out = 0, underrun = 1, state IDLE, busy = 0; no done.
REQ-025 Byte counter SHALL be 8-bit and decrement per consumed byte; no wrap past 0.
REQ-026 done and underrun SHALL never be high together; start in the done/underrun cycle is accepted (state already IDLE).

Reset
REQ-027 On reset: state IDLE, gfsk_out = 0, data_ready = 0, busy = 0, done = 0, underrun = 0, counters and shift register = 0.
REQ-028 Reset mid-frame SHALL abort without done or underrun; gfsk_out = 0 the cycle after reset is sampled.

Structure
REQ-029 Package gfsk_pkg SHALL hold state enum, code constants (OFF=0, ZERO=2, MID=4, ONE=6), PREAMBLE=8'hAA.
REQ-030 Sub-module gfsk_symbol_shaper SHALL own the symbol counter, previous-bit register and code mapping; the top holds FSM, shift register and byte counter.

Verification
REQ-031 SYMBOL_CYCLES=10, access_addr=32'h8E89BED6, length=0, start -> busy 490 cycles, gfsk_out cycle 1..10 = 2, cycle 11 = 4, cycles 12..20 = 6, done at cycle 491.
REQ-032 length=2, bytes 8'hFF, 8'h00 always valid -> exactly 2 handshakes, payload code sequence 6 x80 (first 4 if previous bit 0), then 4, 2 x79; busy 650 cycles.
REQ-033 length=3, data_valid dropped before byte 2 -> underrun pulse, gfsk_out 0 next cycle, no done, busy 0.
REQ-034 start pulsed repeatedly during a frame -> single frame, captured access_addr/length unchanged.
REQ-035 reset asserted at preamble bit 3 -> outputs at reset values next cycle; new start then yields full correct frame.
REQ-036 SYMBOL_CYCLES=2, length=1, data 8'h5A -> each bit 2 cycles, transitions show code 4 on first cycle.
